dmem_arbiter: RTL

Shares the single-port data memory between the pipeline's MEM stage and an external DMA/debug port. Normally the pipeline owns the memory. The DMA port is granted bounded bursts, either when the pipeline is idle or after it has waited a fixed starvation limit. While the DMA owns the memory and the pipeline needs it, the block raises a stall that freezes the pipeline. The block sits between the EXE/MEM pipeline register outputs and the data memory.

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the pipeline MEM stage owns the single-port memory by default, and the
// DMA/debug port is granted bounded bursts when the pipeline is idle or has starved it too long.
module dmem_arbiter #(
  parameter int unsigned MAXBURST = 4,
  parameter int unsigned COOLDOWN = 2,
  parameter int unsigned STARVE   = 3,
  parameter int unsigned AW       = 6
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [31:0]   pAddr,
  input  logic [31:0]   pWdata,
  input  logic          pWe,
  input  logic          pRe,
  output logic [31:0]   pRdata,
  output logic          stall,
  input  logic          dValid,
  output logic          dReady,
  input  logic [AW-1:0] dAddr,
  input  logic [31:0]   dWdata,
  input  logic          dWe,
  output logic          dRvalid,
  output logic [31:0]   dRdata,
  output logic [AW-1:0] memAddr,
  output logic [31:0]   memWdata,
  output logic          memWe,
  input  logic [31:0]   memRdata
);

  localparam int unsigned BW = $clog2(MAXBURST + 1);
  localparam int unsigned CW = $clog2(COOLDOWN + 1);
  localparam int unsigned SW = $clog2(STARVE + 1);

  typedef enum logic [1:0] {StIdle, StDgnt, StCool} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [CW-1:0]   cool_q, cool_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            drvalid_q;
  logic [31:0]     drdata_q;

  logic p_req;
  logic xfer;
  logic dma_rd;

  assign p_req  = pWe | pRe;
  assign xfer   = (state_q == StDgnt) & dValid;
  assign dma_rd = xfer & ~dWe;

  assign pRdata  = memRdata;
  assign dRvalid = drvalid_q;
  assign dRdata  = drdata_q;

  // Only the word-index bits of the pipeline byte address reach the memory.
  logic unused_paddr;
  assign unused_paddr = ^{pAddr[31:AW+2], pAddr[1:0]};

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    cool_d   = cool_q;
    starve_d = starve_q;
    memAddr  = pAddr[AW+1:2];
    memWdata = pWdata;
    memWe    = pWe;
    dReady   = 1'b0;
    stall    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dValid) begin
          if (!p_req || starve_q == SW'(STARVE)) begin
            state_d = StDgnt;
          end else begin
            starve_d = starve_q + SW'(1);
          end
        end else begin
          starve_d = '0;
        end
      end
      StDgnt: begin
        memAddr  = dAddr;
        memWdata = dWdata;
        memWe    = dValid & dWe;
        dReady   = 1'b1;
        stall    = p_req;
        if (!dValid) begin
          state_d  = StIdle;
          burst_d  = '0;
          starve_d = '0;
        end else if (burst_q + BW'(1) == BW'(MAXBURST)) begin
          state_d  = StCool;
          burst_d  = '0;
          starve_d = '0;
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end
      StCool: begin
        // DMA requests wait out the whole cooldown, so starvation does not accumulate here.
        starve_d = '0;
        if (cool_q == CW'(COOLDOWN - 1)) begin
          state_d = StIdle;
          cool_d  = '0;
        end else begin
          cool_d = cool_q + CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      burst_q   <= '0;
      cool_q    <= '0;
      starve_q  <= '0;
      drvalid_q <= 1'b0;
      drdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      cool_q    <= cool_d;
      starve_q  <= starve_d;
      drvalid_q <= dma_rd;
      if (dma_rd) begin
        drdata_q <= memRdata;
      end
    end
  end

endmodule
